// File: rtl/arbiter4_rr.sv
// Four-requester round-robin arbiter with registered one-hot grant.
// A hold limit forces rotation once another requester is waiting.
module arbiter4_rr #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic [1:0] gnt_id
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    G0   = 3'd1,
    G1   = 3'd2,
    G2   = 3'd3,
    G3   = 3'd4
  } state_e;

  localparam logic [7:0] HLIM = 8'(HOLD_MAX - 1);

  state_e     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic       vld_q, vld_d;
  logic [1:0] id_q, id_d;

  logic       busy;
  logic [1:0] own;
  logic [3:0] others;

  // First requester at p+1, p+2, p+3, p+4 (mod 4).
  function automatic logic [1:0] search(
    input logic [1:0] p,
    input logic [3:0] r
  );
    logic [1:0] idx;
    logic [1:0] win;
    win = p;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (r[idx]) win = idx;
    end
    return win;
  endfunction

  function automatic state_e enc(input logic [1:0] w);
    return state_e'(3'(w) + 3'd1);
  endfunction

  always_comb begin
    busy = 1'b1;
    own  = 2'd0;
    unique case (state_q)
      G0:      own = 2'd0;
      G1:      own = 2'd1;
      G2:      own = 2'd2;
      G3:      own = 2'd3;
      default: busy = 1'b0;
    endcase
  end

  assign others = req & ~(4'b0001 << own);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (!busy) begin
      if (|req) begin
        state_d = enc(search(last_q, req));
        last_d  = search(last_q, req);
        cnt_d   = 8'd0;
      end
    end else if (!req[own]) begin
      last_d  = own;
      cnt_d   = 8'd0;
      state_d = (|others) ? enc(search(own, req)) : IDLE;
    end else if (cnt_q < HLIM) begin
      cnt_d = cnt_q + 8'd1;
    end else if (|others) begin
      // Limit reached with a contender waiting: hand over.
      state_d = enc(search(own, req));
      last_d  = own;
      cnt_d   = 8'd0;
    end
  end

  always_comb begin
    gnt_d = 4'b0000;
    vld_d = 1'b0;
    id_d  = 2'd0;
    unique case (state_d)
      G0: begin gnt_d = 4'b0001; vld_d = 1'b1; id_d = 2'd0; end
      G1: begin gnt_d = 4'b0010; vld_d = 1'b1; id_d = 2'd1; end
      G2: begin gnt_d = 4'b0100; vld_d = 1'b1; id_d = 2'd2; end
      G3: begin gnt_d = 4'b1000; vld_d = 1'b1; id_d = 2'd3; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      cnt_q   <= 8'd0;
      gnt_q   <= 4'b0000;
      vld_q   <= 1'b0;
      id_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = vld_q;
  assign gnt_id    = id_q;

endmodule

// File: tb/tb_arbiter4_rr.sv
// Scoreboard bench for arbiter4_rr: directed vectors, then a
// reference-model random phase with per-cycle invariant checks.
module tb_arbiter4_rr;

  localparam int HA = 4;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic [3:0] req_a = 4'b0000;
  logic [3:0] req_b = 4'b0000;
  logic [3:0] gnt_a, gnt_b;
  logic       vld_a, vld_b;
  logic [1:0] id_a, id_b;

  always #5 clk = ~clk;

  arbiter4_rr #(.HOLD_MAX(HA)) u_dut_a (
    .clk(clk), .reset(rst_a), .req(req_a),
    .gnt(gnt_a), .gnt_valid(vld_a), .gnt_id(id_a)
  );

  arbiter4_rr #(.HOLD_MAX(1)) u_dut_b (
    .clk(clk), .reset(rst_b), .req(req_b),
    .gnt(gnt_b), .gnt_valid(vld_b), .gnt_id(id_b)
  );

  typedef struct {
    logic [3:0] g;
    string      tag;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int n_cmp = 0;
  int n_bad = 0;
  int keeps = 0;
  logic [3:0] prev_a = 4'b0000;

  function automatic logic [1:0] oh2id(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [3:0] g,
                     input logic v, input logic [1:0] id,
                     input logic [3:0] eg);
    n_cmp++;
    if (g !== eg || v !== (|eg) || id !== oh2id(eg)) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b valid=%b id=%0d, want gnt=%b valid=%b id=%0d",
               tag, g, v, id, eg, |eg, oh2id(eg));
    end
  endtask

  task automatic inv(input string tag, input logic [3:0] g,
                     input logic v, input logic [1:0] id);
    n_cmp++;
    if ($isunknown({g, v, id}) || !$onehot0(g) ||
        v !== (|g) || id !== oh2id(g)) begin
      n_bad++;
      $display("FAIL %s: gnt=%b valid=%b id=%0d inconsistent",
               tag, g, v, id);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk(ea.tag, gnt_a, vld_a, id_a, ea.g);
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk(eb.tag, gnt_b, vld_b, id_b, eb.g);
    end
    inv("inv_a", gnt_a, vld_a, id_a);
    inv("inv_b", gnt_b, vld_b, id_b);
    if (!rst_a && gnt_a != 4'b0000 && gnt_a == prev_a &&
        (req_a & ~gnt_a) != 4'b0000)
      keeps++;
    else
      keeps = 0;
    n_cmp++;
    if (keeps > HA - 1) begin
      n_bad++;
      $display("FAIL hold_limit: owner %b kept %0d contended edges, max %0d",
               gnt_a, keeps, HA - 1);
    end
    prev_a = gnt_a;
  end

  task automatic drive(input logic [3:0] r, input bit rs, input bit ck,
                       input logic [3:0] eg, input string tag);
    @(negedge clk);
    req_a = r;
    rst_a = rs;
    if (ck) qa.push_back('{g: eg, tag: tag});
  endtask

  task automatic driveb(input logic [3:0] r, input bit rs, input bit ck,
                        input logic [3:0] eg, input string tag);
    @(negedge clk);
    req_b = r;
    rst_b = rs;
    if (ck) qb.push_back('{g: eg, tag: tag});
  endtask

  // Reference model for the random phase
  int         m_own = -1;
  logic [1:0] m_last = 2'd3;
  int         m_cnt = 0;

  function automatic logic [1:0] srch(input logic [1:0] p,
                                      input logic [3:0] r);
    logic [1:0] j;
    for (int k = 1; k <= 4; k++) begin
      j = 2'((int'(p) + k) % 4);
      if (r[j]) return j;
    end
    return p;
  endfunction

  task automatic model(input logic [3:0] r, input bit rs,
                       output logic [3:0] g);
    logic [3:0] oth;
    if (rs) begin
      m_own = -1; m_last = 2'd3; m_cnt = 0;
    end else if (m_own < 0) begin
      if (r != 4'b0000) begin
        m_own = int'(srch(m_last, r));
        m_last = 2'(m_own);
        m_cnt = 0;
      end
    end else begin
      oth = r & ~(4'b0001 << m_own);
      if (!r[m_own]) begin
        m_last = 2'(m_own);
        m_cnt = 0;
        m_own = (oth != 4'b0000) ? int'(srch(2'(m_own), r)) : -1;
      end else if (m_cnt < HA - 1) begin
        m_cnt++;
      end else if (oth != 4'b0000) begin
        m_last = 2'(m_own);
        m_cnt = 0;
        m_own = int'(srch(2'(m_own), r));
      end
    end
    g = (m_own < 0) ? 4'b0000 : 4'(4'b0001 << m_own);
  endtask

  initial begin
    logic [3:0] r, g;
    bit rs;

    // Reset state and single requester
    drive(4'b0000, 1, 1, 4'b0000, "reset_state");
    for (int i = 0; i < 6; i++) drive(4'b0100, 0, 1, 4'b0100, "single_hold");
    drive(4'b0000, 0, 1, 4'b0000, "single_release");

    // Contention with HOLD_MAX=4
    drive(4'b0000, 1, 0, 4'b0000, "");
    for (int i = 0; i < 4; i++) drive(4'b0011, 0, 1, 4'b0001, "cont_g0");
    for (int i = 0; i < 4; i++) drive(4'b0011, 0, 1, 4'b0010, "cont_g1");
    drive(4'b0011, 0, 1, 4'b0001, "cont_back_g0");

    // Release handoff and last=3 priority
    drive(4'b0000, 1, 0, 4'b0000, "");
    drive(4'b0010, 0, 1, 4'b0010, "hand_own1");
    drive(4'b1010, 0, 1, 4'b0010, "hand_hold1");
    drive(4'b1010, 0, 1, 4'b0010, "hand_hold1b");
    drive(4'b1000, 0, 1, 4'b1000, "hand_to3");
    drive(4'b0000, 0, 1, 4'b0000, "hand_idle");
    drive(4'b1001, 0, 1, 4'b0001, "after3_to0");

    // Reset behaviour
    drive(4'b0000, 1, 0, 4'b0000, "");
    drive(4'b0100, 0, 1, 4'b0100, "pre_pulse");
    @(negedge clk);
    qa.push_back('{g: 4'b0100, tag: "short_pulse"});
    #1 rst_a = 1'b1;
    #2 rst_a = 1'b0;
    drive(4'b0100, 1, 1, 4'b0000, "reset_mid_grant");
    drive(4'b0110, 0, 1, 4'b0010, "first_after_reset");

    // Round-robin order with HOLD_MAX=1
    driveb(4'b0000, 1, 1, 4'b0000, "rr_reset");
    driveb(4'b1111, 0, 1, 4'b0001, "rr_0");
    driveb(4'b1111, 0, 1, 4'b0010, "rr_1");
    driveb(4'b1111, 0, 1, 4'b0100, "rr_2");
    driveb(4'b1111, 0, 1, 4'b1000, "rr_3");
    driveb(4'b1111, 0, 1, 4'b0001, "rr_wrap");
    driveb(4'b0000, 0, 0, 4'b0000, "");

    // Random requests and resets against the model
    model(4'b0000, 1, g);
    drive(4'b0000, 1, 1, g, "rnd_reset");
    for (int i = 0; i < 500; i++) begin
      r  = 4'($urandom);
      rs = ($urandom_range(0, 39) == 0);
      model(r, rs, g);
      drive(r, rs, 1, g, "rnd");
    end

    drive(4'b0000, 0, 0, 4'b0000, "");
    repeat (3) @(negedge clk);
    n_cmp++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d/%0d expectations left, want 0/0",
               qa.size(), qb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
